// File: rtl/pa_riscv.sv
// RISC-V opcode constants, field widths and format helpers shared by the instruction encoder.
package pa_riscv;

    localparam int OPC_W   = 7;
    localparam int REG_W   = 5;
    localparam int F3_W    = 3;
    localparam int IMM_W   = 32;
    localparam int INSTR_W = 32;

    localparam logic [OPC_W-1:0] OPC_R = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_S = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_B = 7'b1100011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_NONE
    } fmt_e;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_e;

    function automatic fmt_e decode_fmt(input logic [OPC_W-1:0] opcode);
        fmt_e fmt;
        case (opcode)
            OPC_R:   fmt = FMT_R;
            OPC_I:   fmt = FMT_I;
            OPC_S:   fmt = FMT_S;
            OPC_B:   fmt = FMT_B;
            default: fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    // I/S immediates must be signed 12-bit; B must be signed 13-bit and even.
    function automatic logic imm_in_range(input fmt_e fmt, input logic [IMM_W-1:0] imm);
        logic ok;
        case (fmt)
            FMT_I, FMT_S: ok = (&imm[31:11]) || !(|imm[31:11]);
            FMT_B:        ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Bundle of the instr_encoder request/response signals; master is the environment, slave the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
) (
    input logic clk
);
    logic              req_valid;
    logic              req_ready;
    logic [6:0]        operand;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic              funct7bit5;
    logic [31:0]       imm;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_addr;
    logic [15:0]       count;
    logic              err;

    modport master (
        input  clk,
        output req_valid, operand, rd, rs1, rs2, funct3, funct7bit5, imm, instr_ready,
        input  req_ready, instr_valid, instr, instr_addr, count, err
    );

    modport slave (
        input  clk,
        input  req_valid, operand, rd, rs1, rs2, funct3, funct7bit5, imm, instr_ready,
        output req_ready, instr_valid, instr, instr_addr, count, err
    );
endinterface

// File: rtl/instr_format_pack.sv
// Pure combinational packing of register/immediate fields into a 32-bit R/I/S/B instruction word.
module instr_format_pack
    import pa_riscv::*;
(
    input  fmt_e               fmt,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [REG_W-1:0]   rd,
    input  logic [REG_W-1:0]   rs1,
    input  logic [REG_W-1:0]   rs2,
    input  logic [F3_W-1:0]    funct3,
    input  logic               funct7bit5,
    input  logic [12:0]        imm,
    output logic [INSTR_W-1:0] instr
);

    always_comb begin
        instr = '0;
        case (fmt)
            FMT_R: instr = {1'b0, funct7bit5, 5'b00000, rs2, rs1, funct3, rd, opcode};
            FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            default: instr = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes R/I-load/S/B requests into RISC-V words behind a one-entry valid/ready output register.
// Optional immediate range checking is enabled by defining INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
    import pa_riscv::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_clear,
    input  logic              i_reqValid,
    output logic              o_reqReady,
    input  logic [6:0]        i_operand,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7bit5,
    input  logic [31:0]       i_imm,
    output logic              o_instrValid,
    input  logic              i_instrReady,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_instrAddr,
    output logic [15:0]       o_count,
    output logic              o_err
);

    state_e              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         count_q, count_d;
    logic                err_q, err_d;

    fmt_e                fmt;
    logic                imm_ok;
    logic                req_bad;
    logic                accept;
    logic                load_word;
    logic                complete;
    logic [INSTR_W-1:0]  packed_word;

    assign fmt = decode_fmt(i_operand);

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    assign imm_ok = imm_in_range(fmt, i_imm);
`else
    logic unused_imm_hi;
    assign imm_ok        = 1'b1;
    assign unused_imm_hi = ^i_imm[31:13];
`endif

    instr_format_pack u_pack (
        .fmt        (fmt),
        .opcode     (i_operand),
        .rd         (i_rd),
        .rs1        (i_rs1),
        .rs2        (i_rs2),
        .funct3     (i_funct3),
        .funct7bit5 (i_funct7bit5),
        .imm        (i_imm[12:0]),
        .instr      (packed_word)
    );

    assign o_instrValid = (state_q == ST_FULL);
    assign o_reqReady   = !o_instrValid || i_instrReady;
    assign req_bad      = (fmt == FMT_NONE) || !imm_ok;
    assign accept       = i_reqValid && o_reqReady;
    assign load_word    = accept && !req_bad;
    assign complete     = o_instrValid && i_instrReady;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = 1'b0;

        if (i_clear) begin
            // Clear wins over any handshake in the same cycle, including a new request.
            state_d = ST_EMPTY;
            addr_d  = '0;
            count_d = '0;
        end else begin
            if (complete) begin
                addr_d = addr_q + ADDR_W'(4);
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end

            // A new word loaded in the completion cycle inherits the advanced address.
            if (load_word) begin
                state_d = ST_FULL;
                instr_d = packed_word;
            end else if (complete) begin
                state_d = ST_EMPTY;
            end

            err_d = accept && req_bad;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q <= ST_EMPTY;
            instr_q <= '0;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign o_instr     = instr_q;
    assign o_instrAddr = addr_q;
    assign o_count     = count_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder with a 4-bit address to exercise wrap-around.
module tb_instr_encoder;
    import pa_riscv::*;

    localparam int AW = 4;

    logic clk;
    logic srst;
    logic clear;

    instr_encoder_if #(.ADDR_W(AW)) bus (.clk(clk));

    instr_encoder #(.ADDR_W(AW)) dut (
        .i_clk        (clk),
        .i_srst       (srst),
        .i_clear      (clear),
        .i_reqValid   (bus.req_valid),
        .o_reqReady   (bus.req_ready),
        .i_operand    (bus.operand),
        .i_rd         (bus.rd),
        .i_rs1        (bus.rs1),
        .i_rs2        (bus.rs2),
        .i_funct3     (bus.funct3),
        .i_funct7bit5 (bus.funct7bit5),
        .i_imm        (bus.imm),
        .o_instrValid (bus.instr_valid),
        .i_instrReady (bus.instr_ready),
        .o_instr      (bus.instr),
        .o_instrAddr  (bus.instr_addr),
        .o_count      (bus.count),
        .o_err        (bus.err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    logic [31:0]   sb_q[$];
    logic [AW-1:0] mdl_addr = '0;
    logic [15:0]   mdl_count = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output-side scoreboard: every completed handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (!srst && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_word", bus.instr, 32'hXXXX_XXXX);
            end else begin
                logic [31:0] exp_w;
                exp_w = sb_q.pop_front();
                $display("word %h @ addr %0d (expected %h @ %0d)", bus.instr, bus.instr_addr, exp_w, mdl_addr);
                chk("word", bus.instr, exp_w);
                chk("addr", 32'(bus.instr_addr), 32'(mdl_addr));
                mdl_addr  = mdl_addr + AW'(4);
                mdl_count = mdl_count + 16'd1;
            end
        end
    end

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                         input logic [31:0] imm);
        bus.operand    = op;
        bus.rd         = rd;
        bus.rs1        = rs1;
        bus.rs2        = rs2;
        bus.funct3     = f3;
        bus.funct7bit5 = f7;
        bus.imm        = imm;
        bus.req_valid  = 1'b1;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm, input logic [31:0] exp_word, input bit exp_drop);
        bit got;
        got = 1'b0;
        drive(op, rd, rs1, rs2, f3, f7, imm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("req_accept_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (got) begin
            $display("req op=%b imm=%h -> expect %s %h", op, imm, exp_drop ? "drop" : "word", exp_word);
            chk("err_pulse", 32'(bus.err), 32'(exp_drop));
            if (!exp_drop) begin
                chk("valid_latency", 32'(bus.instr_valid), 32'd1);
                sb_q.push_back(exp_word);
            end
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && bus.instr_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        sb_q.delete();
        mdl_addr  = '0;
        mdl_count = '0;
    endtask

    initial begin
        srst            = 1'b1;
        clear           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.instr_ready = 1'b1;
        drive(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
        bus.req_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_addr", 32'(bus.instr_addr), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        srst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // R add / sub, I load, S store, B branch.
        send(OPC_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 32'h002081B3, 1'b0);
        send(OPC_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 32'h402081B3, 1'b0);
        send(OPC_I, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'd8, 32'h00812283, 1'b0);
        send(OPC_S, 5'd0, 5'd2, 5'd6, 3'd2, 1'b0, 32'd12, 32'h00612623, 1'b0);
        send(OPC_B, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0);
        drain();
        chk("count_after_5", 32'(bus.count), 32'(mdl_count));

        // Out-of-range branch immediate: dropped with the check, truncated without.
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        send(OPC_B, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4096, 32'd0, 1'b1);
`else
        send(OPC_B, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4096, 32'h80208063, 1'b0);
`endif
        drain();
        chk("addr_after_b4096", 32'(bus.instr_addr), 32'(mdl_addr));

        // Unsupported opcode: one-cycle error, no word, nothing advances.
        send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        chk("err_one_cycle", 32'(bus.err), 32'd0);
        chk("valid_after_bad", 32'(bus.instr_valid), 32'd0);
        chk("count_after_bad", 32'(bus.count), 32'(mdl_count));
        chk("addr_after_bad", 32'(bus.instr_addr), 32'(mdl_addr));

        // Clear, then back-to-back requests with a three-cycle downstream stall.
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        flush_model();
        chk("clear_count", 32'(bus.count), 32'd0);
        bus.instr_ready = 1'b0;
        send(OPC_I, 5'd1, 5'd0, 5'd0, 3'd2, 1'b0, 32'd4, 32'h00402083, 1'b0);
        drive(OPC_I, 5'd2, 5'd0, 5'd0, 3'd2, 1'b0, 32'd8);
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_instr", bus.instr, sb_q[0]);
            chk("stall_addr", 32'(bus.instr_addr), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        send(OPC_I, 5'd2, 5'd0, 5'd0, 3'd2, 1'b0, 32'd8, 32'h00802103, 1'b0);
        send(OPC_I, 5'd3, 5'd0, 5'd0, 3'd2, 1'b0, 32'd12, 32'h00C02183, 1'b0);
        send(OPC_I, 5'd4, 5'd0, 5'd0, 3'd2, 1'b0, 32'd16, 32'h01002203, 1'b0);
        drain();
        chk("count_b2b", 32'(bus.count), 32'd4);

        // Address wrap at 2^4: five words land at 0,4,8,12,0.
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        flush_model();
        for (int k = 0; k < 5; k++) begin
            logic [4:0] r;
            r = 5'(k + 1);
            send(OPC_R, r, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, {7'd0, 5'd2, 5'd1, 3'd0, r, OPC_R}, 1'b0);
        end
        drain();
        chk("count_wrap", 32'(bus.count), 32'd5);
        chk("addr_wrap", 32'(bus.instr_addr), 32'd4);

        // Clear while FULL with a concurrent request: both discarded.
        bus.instr_ready = 1'b0;
        send(OPC_S, 5'd0, 5'd3, 5'd4, 3'd2, 1'b0, 32'd0, 32'h0041A023, 1'b0);
        drive(OPC_R, 5'd9, 5'd9, 5'd9, 3'd0, 1'b0, 32'd0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear         = 1'b0;
        bus.req_valid = 1'b0;
        flush_model();
        chk("clear_full_valid", 32'(bus.instr_valid), 32'd0);
        chk("clear_full_addr", 32'(bus.instr_addr), 32'd0);
        chk("clear_full_count", 32'(bus.count), 32'd0);
        bus.instr_ready = 1'b1;
        send(OPC_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 32'h002081B3, 1'b0);
        drain();
        chk("count_after_clear", 32'(bus.count), 32'd1);

        // Reset mid-transfer discards the held word.
        bus.instr_ready = 1'b0;
        send(OPC_R, 5'd7, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 32'h402083B3, 1'b0);
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        flush_model();
        chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
        chk("midrst_instr", bus.instr, 32'd0);
        chk("midrst_count", 32'(bus.count), 32'd0);
        bus.instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_no_word", 32'(bus.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
